// File: rtl/crossbar_sched_if.sv
// Bundles the per-port input flit channels, per-output channels and drop pulse of crossbar_sched.
// The scheduler connects to the slave modport; the traffic source and sink side use master.
interface crossbar_sched_if #(
  parameter int PORTS = 4,
  parameter int WIDTH = 8,
  parameter int DW    = $clog2(PORTS)
);
  logic             valid_i [PORTS];
  logic [WIDTH-1:0] data_i  [PORTS];
  logic [DW-1:0]    dest_i  [PORTS];
  logic             last_i  [PORTS];
  logic             ready_o [PORTS];
  logic             valid_o [PORTS];
  logic [WIDTH-1:0] data_o  [PORTS];
  logic             last_o  [PORTS];
  logic [DW-1:0]    src_o   [PORTS];
  logic             ready_i [PORTS];
  logic             drop_o;

  modport slave (
    input  valid_i, data_i, dest_i, last_i, ready_i,
    output ready_o, valid_o, data_o, last_o, src_o, drop_o
  );

  modport master (
    output valid_i, data_i, dest_i, last_i, ready_i,
    input  ready_o, valid_o, data_o, last_o, src_o, drop_o
  );
endinterface

// File: rtl/crossbar_sched.sv
// Packet-aware round-robin scheduler with one registered output slot per crossbar output.
// Each output locks onto an input until that input's last flit has been accepted.
module crossbar_sched #(
  parameter int PORTS = 4,
  parameter int WIDTH = 8,
  parameter int DW    = $clog2(PORTS)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  crossbar_sched_if.slave  bus
);

  typedef enum logic {IDLE, LOCKED} lock_e;

  localparam int unsigned NP = PORTS;
  localparam logic [PORTS-1:0] ONE = {{(PORTS-1){1'b0}}, 1'b1};

  // (base + off) mod PORTS, with base < PORTS and off < PORTS
  function automatic logic [DW-1:0] wrap_add(input logic [DW-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NP) s = s - NP;
    return s[DW-1:0];
  endfunction

  logic [PORTS-1:0] in_valid;
  logic [PORTS-1:0] bad_dest;
  logic [PORTS-1:0] take [PORTS];

  generate
    for (genvar gi = 0; gi < PORTS; gi++) begin : g_in
      logic rdy_w;

      assign in_valid[gi] = bus.valid_i[gi];
      assign bad_dest[gi] = (32'(bus.dest_i[gi]) >= NP);

      always_comb begin
        rdy_w = 1'b0;
        for (int j = 0; j < PORTS; j++) begin
          rdy_w = rdy_w | take[j][gi];
        end
      end

      // Out-of-range destinations are swallowed so they never block the input
      assign bus.ready_o[gi] = rstn_i && (rdy_w || (bus.valid_i[gi] && bad_dest[gi]));
    end
  endgenerate

  assign bus.drop_o = rstn_i && (|(in_valid & bad_dest));

  generate
    for (genvar gi = 0; gi < PORTS; gi++) begin : g_out
      lock_e            state_q, state_d;
      logic [DW-1:0]    owner_q, owner_d;
      logic [DW-1:0]    ptr_q, ptr_d;
      logic             valid_q, valid_d;
      logic [WIDTH-1:0] data_q, data_d;
      logic             last_q, last_d;
      logic [DW-1:0]    src_q, src_d;

      logic [PORTS-1:0] elig;
      logic             gnt_vld;
      logic [DW-1:0]    gnt_idx;
      logic             can_load;

      for (genvar gk = 0; gk < PORTS; gk++) begin : g_elig
        assign elig[gk] = bus.valid_i[gk] && (bus.dest_i[gk] == DW'(gi)) &&
                          ((state_q == IDLE) || (owner_q == DW'(gk)));
      end

      assign can_load = !valid_q || bus.ready_i[gi];

      // Scan downward so the closest eligible input at or after ptr wins
      always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int off = PORTS - 1; off >= 0; off--) begin
          if (elig[wrap_add(ptr_q, unsigned'(off))]) begin
            gnt_vld = 1'b1;
            gnt_idx = wrap_add(ptr_q, unsigned'(off));
          end
        end
      end

      assign take[gi] = (gnt_vld && can_load) ? (ONE << gnt_idx) : '0;

      always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        src_d   = src_q;
        if (gnt_vld && can_load) begin
          valid_d = 1'b1;
          data_d  = bus.data_i[gnt_idx];
          last_d  = bus.last_i[gnt_idx];
          src_d   = gnt_idx;
          if (bus.last_i[gnt_idx]) begin
            state_d = IDLE;
            ptr_d   = wrap_add(gnt_idx, 1);
          end else begin
            state_d = LOCKED;
            owner_d = gnt_idx;
          end
        end else if (bus.ready_i[gi]) begin
          valid_d = 1'b0;
        end
      end

      always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
          state_q <= IDLE;
          owner_q <= '0;
          ptr_q   <= '0;
          valid_q <= 1'b0;
          data_q  <= '0;
          last_q  <= 1'b0;
          src_q   <= '0;
        end else begin
          state_q <= state_d;
          owner_q <= owner_d;
          ptr_q   <= ptr_d;
          valid_q <= valid_d;
          data_q  <= data_d;
          last_q  <= last_d;
          src_q   <= src_d;
        end
      end

      assign bus.valid_o[gi] = valid_q;
      assign bus.data_o[gi]  = data_q;
      assign bus.last_o[gi]  = last_q;
      assign bus.src_o[gi]   = src_q;
    end
  endgenerate

endmodule

// File: tb/tb_crossbar_sched.sv
// Directed scoreboard bench for crossbar_sched: a 4-port and a 3-port instance share clock and reset.
// Expected output flits are queued per output when driven and popped on each output handshake.
module tb_crossbar_sched;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  crossbar_sched_if #(.PORTS(4), .WIDTH(8)) b4 ();
  crossbar_sched_if #(.PORTS(3), .WIDTH(8)) b3 ();

  crossbar_sched #(.PORTS(4), .WIDTH(8)) u4 (.clk_i(clk), .rstn_i(rstn), .bus(b4.slave));
  crossbar_sched #(.PORTS(3), .WIDTH(8)) u3 (.clk_i(clk), .rstn_i(rstn), .bus(b3.slave));

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [1:0] src;
  } flit_t;

  flit_t exp4_q [4][$];
  flit_t exp3_q [3][$];
  int n_tests = 0;
  int n_fail  = 0;
  int pop4_cnt = 0;
  int kk [4];
  int cnt;
  int exp_src;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    flit_t e;
    if (rstn) begin
      for (int j = 0; j < 4; j++) begin
        if (b4.valid_o[j] && b4.ready_i[j]) begin
          pop4_cnt++;
          $display("[TB] p4 out%0d data=%02h src=%0d last=%0d", j, b4.data_o[j], b4.src_o[j], b4.last_o[j]);
          if (exp4_q[j].size() == 0) begin
            check($sformatf("p4_out%0d_unexpected", j), 1, 0);
          end else begin
            e = exp4_q[j].pop_front();
            check($sformatf("p4_out%0d_data", j), b4.data_o[j], e.data);
            check($sformatf("p4_out%0d_last", j), b4.last_o[j], e.last);
            check($sformatf("p4_out%0d_src", j), b4.src_o[j], e.src);
          end
        end
      end
      for (int j = 0; j < 3; j++) begin
        if (b3.valid_o[j] && b3.ready_i[j]) begin
          $display("[TB] p3 out%0d data=%02h src=%0d last=%0d", j, b3.data_o[j], b3.src_o[j], b3.last_o[j]);
          if (exp3_q[j].size() == 0) begin
            check($sformatf("p3_out%0d_unexpected", j), 1, 0);
          end else begin
            e = exp3_q[j].pop_front();
            check($sformatf("p3_out%0d_data", j), b3.data_o[j], e.data);
            check($sformatf("p3_out%0d_last", j), b3.last_o[j], e.last);
            check($sformatf("p3_out%0d_src", j), b3.src_o[j], e.src);
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int i = 0; i < 4; i++) begin
      b4.valid_i[i] = 1'b0; b4.data_i[i] = '0; b4.dest_i[i] = '0;
      b4.last_i[i]  = 1'b0; b4.ready_i[i] = 1'b1;
    end
    for (int i = 0; i < 3; i++) begin
      b3.valid_i[i] = 1'b0; b3.data_i[i] = '0; b3.dest_i[i] = '0;
      b3.last_i[i]  = 1'b0; b3.ready_i[i] = 1'b1;
    end
  endtask

  task automatic drv4(input int i, input logic [7:0] d, input logic [1:0] dst, input logic l);
    b4.valid_i[i] = 1'b1; b4.data_i[i] = d; b4.dest_i[i] = dst; b4.last_i[i] = l;
  endtask

  task automatic drv3(input int i, input logic [7:0] d, input logic [1:0] dst, input logic l);
    b3.valid_i[i] = 1'b1; b3.data_i[i] = d; b3.dest_i[i] = dst; b3.last_i[i] = l;
  endtask

  task automatic push4(input int j, input logic [7:0] d, input logic l, input logic [1:0] s);
    exp4_q[j].push_back(flit_t'({d, l, s}));
  endtask

  task automatic push3(input int j, input logic [7:0] d, input logic l, input logic [1:0] s);
    exp3_q[j].push_back(flit_t'({d, l, s}));
  endtask

  task automatic do_reset();
    idle_all();
    rstn = 1'b0;
    cyc();
    cyc();
    for (int j = 0; j < 4; j++) exp4_q[j].delete();
    for (int j = 0; j < 3; j++) exp3_q[j].delete();
    pop4_cnt = 0;
    rstn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    idle_all();
    cyc();
    cyc();

    // Reset state, with requests present to confirm ready/drop are forced low
    drv4(0, 8'hFF, 2'd0, 1'b1);
    drv3(0, 8'hEE, 2'd3, 1'b1);
    #2;
    for (int j = 0; j < 4; j++) begin
      check($sformatf("rst_valid%0d", j), b4.valid_o[j], 0);
      check($sformatf("rst_data%0d", j), b4.data_o[j], 0);
      check($sformatf("rst_src%0d", j), b4.src_o[j], 0);
      check($sformatf("rst_last%0d", j), b4.last_o[j], 0);
    end
    check("rst_ready", b4.ready_o[0], 0);
    check("rst_drop", b3.drop_o, 0);
    check("rst_ready_p3", b3.ready_o[0], 0);
    idle_all();
    rstn = 1'b1;

    // Single flit: input 2 -> output 1
    cyc();
    drv4(2, 8'hA5, 2'd1, 1'b1);
    push4(1, 8'hA5, 1'b1, 2'd2);
    #2;
    for (int i = 0; i < 4; i++) check($sformatf("sf_ready%0d", i), b4.ready_o[i], (i == 2) ? 1 : 0);
    cyc();
    idle_all();
    #2;
    check("sf_valid1", b4.valid_o[1], 1);
    check("sf_data1", b4.data_o[1], 8'hA5);
    check("sf_src1", b4.src_o[1], 2);
    for (int j = 0; j < 4; j++) if (j != 1) check($sformatf("sf_idle%0d", j), b4.valid_o[j], 0);
    cyc();
    check("sf_drained", b4.valid_o[1], 0);
    check("sf_sb", exp4_q[1].size(), 0);

    // Round-robin: all inputs stream single-flit packets to output 0
    do_reset();
    for (int i = 0; i < 4; i++) kk[i] = 0;
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < 4; i++) drv4(i, 8'(i * 16 + kk[i]), 2'd0, 1'b1);
      exp_src = c % 4;
      push4(0, 8'(exp_src * 16 + kk[exp_src]), 1'b1, 2'(exp_src));
      #2;
      cnt = 0;
      for (int i = 0; i < 4; i++) cnt += int'(b4.ready_o[i]);
      check("rr_onehot", cnt, 1);
      check($sformatf("rr_grant_c%0d", c), b4.ready_o[exp_src], 1);
      kk[exp_src]++;
      cyc();
    end
    idle_all();
    cyc();
    cyc();
    check("rr_sb", exp4_q[0].size(), 0);
    check("rr_count", pop4_cnt, 12);

    // Packet lock: 3-flit packet from input 3 while input 0 waits on output 2
    do_reset();
    drv4(3, 8'h11, 2'd2, 1'b0); push4(2, 8'h11, 1'b0, 2'd3);
    #2; check("lk_first", b4.ready_o[3], 1);
    cyc();
    drv4(3, 8'h22, 2'd2, 1'b0); drv4(0, 8'h40, 2'd2, 1'b1); push4(2, 8'h22, 1'b0, 2'd3);
    #2; check("lk_stall_a", b4.ready_o[0], 0); check("lk_owner_a", b4.ready_o[3], 1);
    cyc();
    drv4(3, 8'h33, 2'd2, 1'b1); push4(2, 8'h33, 1'b1, 2'd3);
    #2; check("lk_stall_b", b4.ready_o[0], 0);
    cyc();
    b4.valid_i[3] = 1'b0; push4(2, 8'h40, 1'b1, 2'd0);
    #2; check("lk_release", b4.ready_o[0], 1);
    cyc();
    idle_all();
    cyc();
    cyc();
    check("lk_sb", exp4_q[2].size(), 0);

    // Packet lock with a one-cycle gap from the owner
    do_reset();
    drv4(3, 8'h11, 2'd2, 1'b0); push4(2, 8'h11, 1'b0, 2'd3);
    cyc();
    b4.valid_i[3] = 1'b0; drv4(0, 8'h40, 2'd2, 1'b1);
    #2; check("gap_stall", b4.ready_o[0], 0);
    cyc();
    check("gap_bubble", b4.valid_o[2], 0);
    drv4(3, 8'h22, 2'd2, 1'b0); push4(2, 8'h22, 1'b0, 2'd3);
    #2; check("gap_stall_b", b4.ready_o[0], 0);
    cyc();
    drv4(3, 8'h33, 2'd2, 1'b1); push4(2, 8'h33, 1'b1, 2'd3);
    #2; check("gap_stall_c", b4.ready_o[0], 0);
    cyc();
    b4.valid_i[3] = 1'b0; push4(2, 8'h40, 1'b1, 2'd0);
    #2; check("gap_release", b4.ready_o[0], 1);
    cyc();
    idle_all();
    cyc();
    cyc();
    check("gap_sb", exp4_q[2].size(), 0);

    // Back-pressure on output 1
    do_reset();
    b4.ready_i[1] = 1'b0;
    drv4(0, 8'h5A, 2'd1, 1'b1); push4(1, 8'h5A, 1'b1, 2'd0);
    #2; check("bp_first", b4.ready_o[0], 1);
    cyc();
    b4.valid_i[0] = 1'b0;
    drv4(1, 8'h6B, 2'd1, 1'b1);
    for (int t = 0; t < 5; t++) begin
      #2;
      check("bp_hold_valid", b4.valid_o[1], 1);
      check("bp_hold_data", b4.data_o[1], 8'h5A);
      check("bp_hold_src", b4.src_o[1], 0);
      check("bp_blocked", b4.ready_o[1], 0);
      cyc();
    end
    b4.ready_i[1] = 1'b1; push4(1, 8'h6B, 1'b1, 2'd1);
    #2; check("bp_unblock", b4.ready_o[1], 1);
    cyc();
    idle_all();
    cyc();
    cyc();
    check("bp_sb", exp4_q[1].size(), 0);
    check("bp_count", pop4_cnt, 2);

    // Parallel grants and out-of-range drop on the 3-port instance
    do_reset();
    drv3(0, 8'h70, 2'd2, 1'b1); push3(2, 8'h70, 1'b1, 2'd0);
    drv3(1, 8'h71, 2'd0, 1'b1); push3(0, 8'h71, 1'b1, 2'd1);
    drv3(2, 8'h72, 2'd1, 1'b1); push3(1, 8'h72, 1'b1, 2'd2);
    #2;
    for (int i = 0; i < 3; i++) check($sformatf("par_ready%0d", i), b3.ready_o[i], 1);
    check("par_nodrop", b3.drop_o, 0);
    cyc();
    idle_all();
    for (int j = 0; j < 3; j++) check($sformatf("par_valid%0d", j), b3.valid_o[j], 1);
    drv3(0, 8'h77, 2'd3, 1'b1);
    #2;
    check("drop_ready", b3.ready_o[0], 1);
    check("drop_pulse", b3.drop_o, 1);
    cyc();
    idle_all();
    #2;
    for (int j = 0; j < 3; j++) check($sformatf("drop_novalid%0d", j), b3.valid_o[j], 0);
    check("drop_pulse_end", b3.drop_o, 0);
    for (int j = 0; j < 3; j++) check($sformatf("par_sb%0d", j), exp3_q[j].size(), 0);

    // Reset in the middle of a locked packet
    do_reset();
    drv4(1, 8'h81, 2'd3, 1'b0);
    #2; check("mr_first", b4.ready_o[1], 1);
    cyc();
    check("mr_held", b4.data_o[3], 8'h81);
    drv4(1, 8'h82, 2'd3, 1'b0);
    rstn = 1'b0;
    #2; check("mr_ready_forced", b4.ready_o[1], 0);
    cyc();
    for (int j = 0; j < 4; j++) begin
      check($sformatf("mr_valid%0d", j), b4.valid_o[j], 0);
      check($sformatf("mr_data%0d", j), b4.data_o[j], 0);
      check($sformatf("mr_src%0d", j), b4.src_o[j], 0);
    end
    rstn = 1'b1;
    b4.valid_i[1] = 1'b0;
    drv4(2, 8'h90, 2'd3, 1'b1); push4(3, 8'h90, 1'b1, 2'd2);
    #2; check("mr_new_owner", b4.ready_o[2], 1);
    cyc();
    idle_all();
    cyc();
    cyc();
    check("mr_sb", exp4_q[3].size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
